// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions.
//  TAPS      : one maximal-length tap mask per width 3..32 (index = width).
//  lfsr_state_t : controller states.
//  lfsr_next : single-step next state for a given width and form. The state is
//              carried right-aligned in 32 bits, and the bits above the width stay 0.
package lfsr_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} lfsr_state_t;

  // Bit k set means stage k+1 is tapped. The Fibonacci form uses the mask as the
  // feedback parity set. The Galois form uses the mask as the toggle mask on the out bit.
  localparam logic [31:0] TAPS [0:32] = '{
    32'h0,        32'h0,        32'h0,        32'h6,
    32'hC,        32'h14,       32'h30,       32'h60,
    32'hB8,       32'h110,      32'h240,      32'h500,
    32'h829,      32'h100D,     32'h2015,     32'h6000,
    32'hD008,     32'h12000,    32'h20400,    32'h40023,
    32'h90000,    32'h140000,   32'h300000,   32'h420000,
    32'hE10000,   32'h1200000,  32'h2000023,  32'h4000013,
    32'h9000000,  32'h14000000, 32'h20000029, 32'h48000000,
    32'h80200003
  };

  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input int unsigned w,
                                            input bit galois);
    logic [31:0] t, wm;
    t  = TAPS[w[5:0]];
    wm = 32'hFFFF_FFFF >> (32 - w);
    if (galois) lfsr_next = (s >> 1) ^ (s[0] ? t : 32'h0);
    else        lfsr_next = ((s << 1) | {31'h0, ^(s & t)}) & wm;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational STEPS-fold unrolled LFSR next state.
//  cur : current state (WIDTH)
//  nxt : state after STEPS single steps (WIDTH)
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int GALOIS = 0,
  parameter int STEPS  = 1
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  logic [STEPS:0][WIDTH-1:0] chain;

  assign chain[0] = cur;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    assign chain[i+1] = WIDTH'(lfsr_next(32'(chain[i]), WIDTH, GALOIS != 0));
  end

  assign nxt = chain[STEPS];

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised maximal-length LFSR source with seed load, step enable and
// first-period tracking.
//  clk, reset      : rising-edge clock, async active-low reset
//  load, seed      : capture seed next edge (0 becomes 1); load beats en
//  en              : advance STEPS steps per cycle once running
//  shift_seed      : current state
//  running         : a seed has been loaded since reset
//  wrap            : one-cycle pulse after the state returns to the loaded seed
//  period          : steps from load to first wrap; 0 until then
//  period_ok       : sticky, first period equalled 2^WIDTH-1
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int GALOIS = 0,
  parameter int STEPS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  output logic [WIDTH-1:0] shift_seed,
  output logic             running,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_ok
);

  // The step counter has one bit more than the state, so a full period never overflows it.
  localparam int            CW   = WIDTH + 1;
  localparam logic [CW-1:0] FULL = {1'b0, {WIDTH{1'b1}}};
  localparam logic [CW:0]   INC  = (CW+1)'(STEPS);

  lfsr_state_t      state, state_nxt;
  logic [WIDTH-1:0] nxt, ref_seed, seed_g;
  logic [CW-1:0]    step_cnt, cnt_new;
  logic [CW:0]      cnt_sum;
  logic             hit, seen_wrap;

  // An all-zero state is the LFSR lock-up point, so such a seed is never allowed in.
  assign seed_g = (seed == '0) ? WIDTH'(1) : seed;

  lfsr_step #(.WIDTH(WIDTH), .GALOIS(GALOIS), .STEPS(STEPS)) u_step (
    .cur (shift_seed),
    .nxt (nxt)
  );

  assign cnt_sum = {1'b0, step_cnt} + INC;
  assign cnt_new = cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
  assign hit     = (nxt == ref_seed);

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign running = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_seed <= '0;
      ref_seed   <= '0;
      step_cnt   <= '0;
      period     <= '0;
      period_ok  <= 1'b0;
      wrap       <= 1'b0;
      seen_wrap  <= 1'b0;
    end else if (load) begin
      shift_seed <= seed_g;
      ref_seed   <= seed_g;
      step_cnt   <= '0;
      period     <= '0;
      period_ok  <= 1'b0;
      wrap       <= 1'b0;
      seen_wrap  <= 1'b0;
    end else if (state == RUN && en) begin
      shift_seed <= nxt;
      step_cnt   <= cnt_new;
      wrap       <= hit;
      // Only the first return to the seed defines the period.
      if (hit && !seen_wrap) begin
        seen_wrap <= 1'b1;
        period    <= cnt_new[WIDTH-1:0];
        period_ok <= (cnt_new == FULL);
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
